// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the variable-latency data-memory responder.
package dmem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int unsigned LAT_W     = 4;

endpackage

// File: rtl/dmem_resp_lfsr16.sv
// 16-bit Fibonacci LFSR used to draw random extra stall cycles.
module lfsr16
   import dmem_resp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= LFSR_SEED;
      end else if (en) begin
         q <= {q[14:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder answering each request after a fixed (or randomly
// stretched, with DMEM_RESP_RAND_STALL_EN) latency with data and a done pulse.
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int unsigned NUM_MEM_WORDS = 2**15,
   parameter int unsigned RD_LATENCY    = 2,
   parameter int unsigned WR_LATENCY    = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic        i_rd_wr,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data_in,
   output logic [31:0] o_data_out,
   output logic        o_done,
   output logic        o_err,
   output logic        o_busy
);

   localparam int unsigned AW = $clog2(NUM_MEM_WORDS);

   dmem_state_e      state;
   logic [LAT_W-1:0] cnt;
   logic             lat_rd_wr;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_data;
   logic [31:0]      mem [NUM_MEM_WORDS];

   logic [1:0]       stall_c;
   logic [LAT_W-1:0] load_c;
   logic             req_rd_wr_c;
   logic [31:0]      req_addr_c;
   logic [31:0]      req_data_c;
   logic [AW-1:0]    idx_c;
   logic             err_c;
   logic             enter_resp_c;

`ifdef DMEM_RESP_RAND_STALL_EN
   logic [15:0] lfsr_q;
   logic        unused_lfsr_bits;

   lfsr16 u_lfsr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (1'b1),
      .q     (lfsr_q)
   );

   assign stall_c          = lfsr_q[1:0];
   assign unused_lfsr_bits = ^lfsr_q[15:2];
`else
   assign stall_c = 2'd0;
`endif

   assign load_c = (i_rd_wr ? LAT_W'(WR_LATENCY - 1) : LAT_W'(RD_LATENCY - 1))
                   + LAT_W'(stall_c);

   // In IDLE the request comes straight from the inputs (zero-wait case); afterwards from the latches
   assign req_rd_wr_c = (state == IDLE) ? i_rd_wr   : lat_rd_wr;
   assign req_addr_c  = (state == IDLE) ? i_addr    : lat_addr;
   assign req_data_c  = (state == IDLE) ? i_data_in : lat_data;

   assign idx_c = req_addr_c[AW+1:2];
   assign err_c = (req_addr_c[1:0] != 2'b00) || ((req_addr_c >> (AW + 2)) != 32'd0);

   assign enter_resp_c = ((state == IDLE) && i_en && (load_c == '0))
                      || ((state == WAIT) && (cnt == LAT_W'(1)));

   // Array is deliberately left out of the reset branch so contents survive reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_rd_wr  <= 1'b0;
         lat_addr   <= '0;
         lat_data   <= '0;
         o_data_out <= '0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_en) begin
                  lat_rd_wr <= i_rd_wr;
                  lat_addr  <= i_addr;
                  lat_data  <= i_data_in;
                  cnt       <= load_c;
                  o_busy    <= 1'b1;
                  state     <= (load_c == '0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - LAT_W'(1);
               if (cnt == LAT_W'(1)) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state  <= IDLE;
               o_done <= 1'b0;
               o_err  <= 1'b0;
               o_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         if (enter_resp_c) begin
            o_done <= 1'b1;
            o_err  <= err_c;
            if (err_c) begin
               o_data_out <= '0;
            end else if (req_rd_wr_c) begin
               mem[idx_c] <= req_data_c;
            end else begin
               o_data_out <= mem[idx_c];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: expectations queued at acceptance, checked on done.
`timescale 1ns/1ps
module tb_dmem_resp;

   localparam int unsigned RD_LAT      = 2;
   localparam int unsigned WR_LAT      = 1;
   localparam int unsigned SLOW_WR_LAT = 3;
`ifdef DMEM_RESP_RAND_STALL_EN
   localparam int unsigned MAX_STALL = 3;
`else
   localparam int unsigned MAX_STALL = 0;
`endif

   typedef struct {
      logic [31:0] data;
      logic        err;
      int unsigned acc;
      int unsigned lat_lo;
      int unsigned lat_hi;
   } exp_t;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        en      = 1'b0;
   logic        en_s    = 1'b0;
   logic        rd_wr   = 1'b0;
   logic [31:0] addr    = 32'h0;
   logic [31:0] data_in = 32'h0;
   logic [31:0] data_out, data_out_s;
   logic        done, err, busy, done_s, err_s, busy_s;

   int          checks = 0;
   int          errors = 0;
   int unsigned ncyc   = 0;
   exp_t        sb[$];
   int unsigned done_cycs[$];
   logic [31:0] model_mem [int unsigned];
   logic [31:0] last_out = 32'h0;
   bit          seen_lat [4];
   exp_t        mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   dmem_resp #(.RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rd_wr(rd_wr), .i_addr(addr),
      .i_data_in(data_in), .o_data_out(data_out), .o_done(done), .o_err(err), .o_busy(busy)
   );

   // Second instance with a longer write latency so a write can be caught in WAIT
   dmem_resp #(.RD_LATENCY(RD_LAT), .WR_LATENCY(SLOW_WR_LAT)) dut_slow (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en_s), .i_rd_wr(rd_wr), .i_addr(addr),
      .i_data_in(data_in), .o_data_out(data_out_s), .o_done(done_s), .o_err(err_s),
      .o_busy(busy_s)
   );

   // Scoreboard consumer for the main instance
   always @(negedge clk) begin
      if (done) begin
         done_cycs.push_back(ncyc);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done at cycle %0d", ncyc);
         end else begin
            mon_e = sb.pop_front();
            if (data_out !== mon_e.data) begin
               errors++;
               $display("FAIL done_data got %h exp %h", data_out, mon_e.data);
            end
            checks++;
            if (err !== mon_e.err) begin
               errors++;
               $display("FAIL done_err got %b exp %b", err, mon_e.err);
            end
            checks++;
            if ((ncyc - mon_e.acc) < mon_e.lat_lo || (ncyc - mon_e.acc) > mon_e.lat_hi) begin
               errors++;
               $display("FAIL latency got %0d exp %0d..%0d", ncyc - mon_e.acc,
                        mon_e.lat_lo, mon_e.lat_hi);
            end else begin
               seen_lat[ncyc - mon_e.acc - mon_e.lat_lo] = 1'b1;
            end
         end
      end
   end

   function automatic exp_t model_req(input logic wr, input logic [31:0] a,
                                      input logic [31:0] d);
      exp_t        e;
      logic        bad;
      int unsigned idx;
      bad      = (a[1:0] != 2'b00) || ((a >> 17) != 32'd0);
      idx      = 32'(a[16:2]);
      e.err    = bad;
      e.acc    = 0;
      e.lat_lo = wr ? WR_LAT : RD_LAT;
      e.lat_hi = e.lat_lo + MAX_STALL;
      if (bad) begin
         e.data = 32'h0;
      end else if (wr) begin
         model_mem[idx] = d;
         e.data = last_out;
      end else begin
         e.data = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      end
      last_out = e.data;
      return e;
   endfunction

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending %0d exp 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      @(negedge clk);
      en = 1'b1; rd_wr = wr; addr = a; data_in = d;
      e = model_req(wr, a, d);
      @(posedge clk);
      e.acc = ncyc;
      sb.push_back(e);
      @(negedge clk);
      en = 1'b0;
      wait_drain();
   endtask

   task automatic slow_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] q, output logic e, output bit ok);
      ok = 0; q = '0; e = 1'b0;
      @(negedge clk);
      en_s = 1'b1; rd_wr = wr; addr = a; data_in = d;
      @(posedge clk);
      @(negedge clk);
      en_s = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (done_s) begin
            ok = 1; q = data_out_s; e = err_s;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 4;
      if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      if (err !== 1'b0)       begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", data_out); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write_read();
      issue(1'b1, 32'h100, 32'hDEADBEEF);
      issue(1'b0, 32'h100, 32'h0);
   endtask

   task automatic test_errors();
      issue(1'b0, 32'h102, 32'h0);
      issue(1'b0, 32'h100, 32'h0);
      issue(1'b1, 32'h101, 32'h0BAD0BAD);
      issue(1'b0, 32'h0002_0000, 32'h0);
      issue(1'b1, 32'h0002_0100, 32'h0BAD0BAD);
      issue(1'b0, 32'h100, 32'h0);
      issue(1'b0, 32'h0001_FFFC, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      exp_t        e;
      bit          seen;
      addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
      for (int k = 0; k < 3; k++) issue(1'b1, addrs[k], 32'hA5A5_0000 + 32'(k * 17 + 3));
      done_cycs.delete();
      @(negedge clk);
      en = 1'b1; rd_wr = 1'b0; addr = addrs[0];
      for (int k = 0; k < 3; k++) begin
         e = model_req(1'b0, addrs[k], 32'h0);
         @(posedge clk);
         e.acc = ncyc;
         sb.push_back(e);
         if (k < 2) begin
            seen = 0;
            for (int i = 0; i < 30 && !seen; i++) begin
               @(negedge clk);
               seen = done;
            end
            if (!seen) begin
               checks++; errors++;
               $display("FAIL b2b_done_timeout req %0d got none exp pulse", k);
               break;
            end
            addr = addrs[k + 1];
            @(posedge clk);
         end
      end
      @(negedge clk);
      en = 1'b0;
      wait_drain();
      repeat (4) @(negedge clk);
      checks++;
      if (done_cycs.size() != 3) begin
         errors++;
         $display("FAIL b2b_pulse_count got %0d exp 3", done_cycs.size());
      end
`ifndef DMEM_RESP_RAND_STALL_EN
      else begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (done_cycs[k] - done_cycs[k - 1] != RD_LAT + 1) begin
               errors++;
               $display("FAIL b2b_spacing got %0d exp %0d", done_cycs[k] - done_cycs[k - 1],
                        RD_LAT + 1);
            end
         end
      end
`endif
   endtask

   task automatic test_addr_change();
      exp_t e;
      issue(1'b1, 32'h100, 32'h1234_5678);
      issue(1'b1, 32'h200, 32'hCAFE_F00D);
      @(negedge clk);
      en = 1'b1; rd_wr = 1'b0; addr = 32'h100;
      e = model_req(1'b0, 32'h100, 32'h0);
      @(posedge clk);
      e.acc = ncyc;
      sb.push_back(e);
      @(negedge clk);
      en = 1'b0; addr = 32'h200; rd_wr = 1'b1; data_in = 32'hFFFF_FFFF;
      wait_drain();
      issue(1'b0, 32'h200, 32'h0);
   endtask

   task automatic test_reset_midflight();
      logic [31:0] q;
      logic        e;
      bit          ok;
      bit          seen;
      slow_op(1'b1, 32'h40, 32'h11, q, e, ok);
      checks++;
      if (!ok || e !== 1'b0) begin
         errors++;
         $display("FAIL slow_prime ok %0d err %b exp ok 1 err 0", ok, e);
      end
      repeat (2) @(negedge clk);
      @(negedge clk);
      en_s = 1'b1; rd_wr = 1'b1; addr = 32'h40; data_in = 32'h5;
      @(posedge clk);
      @(negedge clk);
      en_s = 1'b0;
      checks++;
      if (busy_s !== 1'b1 || done_s !== 1'b0) begin
         errors++;
         $display("FAIL midflight_state busy %b done %b exp busy 1 done 0", busy_s, done_s);
      end
      rst_n = 1'b0;
      #1;
      checks += 2;
      if ({done, err, busy, data_out} !== 35'h0) begin
         errors++;
         $display("FAIL rst_main_outputs got %h exp 0", {done, err, busy, data_out});
      end
      if ({done_s, err_s, busy_s, data_out_s} !== 35'h0) begin
         errors++;
         $display("FAIL rst_slow_outputs got %h exp 0", {done_s, err_s, busy_s, data_out_s});
      end
      last_out = 32'h0;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_s) seen = 1;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done_s) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL aborted_done got pulse exp none");
      end
      slow_op(1'b0, 32'h40, 32'h0, q, e, ok);
      checks++;
      if (!ok || q !== 32'h11 || e !== 1'b0) begin
         errors++;
         $display("FAIL aborted_write_read ok %0d got %h err %b exp 00000011 err 0", ok, q, e);
      end
      issue(1'b0, 32'h100, 32'h0);
   endtask

`ifdef DMEM_RESP_RAND_STALL_EN
   task automatic test_random_stall();
      logic [31:0] pool [4];
      pool[0] = 32'h0; pool[1] = 32'h4; pool[2] = 32'h100; pool[3] = 32'h200;
      for (int i = 0; i < 4; i++) seen_lat[i] = 1'b0;
      for (int i = 0; i < 1000; i++) issue(1'b0, pool[$urandom_range(0, 3)], 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (!seen_lat[i]) begin
            errors++;
            $display("FAIL stall_coverage latency %0d seen 0 exp 1", RD_LAT + i);
         end
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_errors();
      test_back_to_back();
      test_addr_change();
      test_reset_midflight();
`ifdef DMEM_RESP_RAND_STALL_EN
      test_random_stall();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
